// File: rtl/palette_mapper.sv
// Programmable RGB palette lookup with a fixed 2-cycle latency and per-channel dimming.
// Palette lives in flops; restore and reset reload the built-in colour set.
module palette_mapper #(
  parameter int IDX_W = 4,
  parameter int CH_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic [1:0]          dim,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [3*CH_W-1:0]   wr_rgb,
  input  logic                restore,
  output logic                out_valid,
  output logic [3*CH_W-1:0]   out_rgb
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned CW    = CH_W;
  localparam int unsigned RGB_W = 3 * CH_W;

  // Bit b from the MSB takes source bit (b mod 8): truncates when narrow, replicates when wide.
  function automatic logic [CH_W-1:0] scale8(input logic [7:0] c);
    logic [CH_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < CW; b++) begin
      r[CW-1-b] = c[7-(b%8)];
    end
    return r;
  endfunction

  function automatic logic [RGB_W-1:0] default_rgb(input int unsigned i);
    logic [23:0] h;
    case (i)
      0:       h = 24'h000000;
      1:       h = 24'hb97a56;
      2:       h = 24'he49a9d;
      3:       h = 24'hffaec8;
      4:       h = 24'h808080;
      5:       h = 24'h404040;
      6:       h = 24'hc0c0c0;
      7:       h = 24'hff00ff;
      8:       h = 24'h00f0f0;
      9:       h = 24'h0000f0;
      10:      h = 24'hf0a000;
      11:      h = 24'hf0f000;
      12:      h = 24'h00f000;
      13:      h = 24'ha000f0;
      14:      h = 24'hf00000;
      15:      h = 24'hffffff;
      default: h = 24'h000000;
    endcase
    return {scale8(h[23:16]), scale8(h[15:8]), scale8(h[7:0])};
  endfunction

  logic [RGB_W-1:0] pal_q [DEPTH];
  logic [RGB_W-1:0] pal_d [DEPTH];

  logic             s1_valid_q;
  logic [1:0]       s1_dim_q;
  logic [RGB_W-1:0] s1_rgb_q;

  logic             out_valid_q;
  logic [RGB_W-1:0] out_rgb_q;
  logic [RGB_W-1:0] out_rgb_d;

  always_comb begin
    pal_d = pal_q;
    if (restore) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pal_d[i[IDX_W-1:0]] = default_rgb(i);
      end
    end else if (wr_en) begin
      pal_d[wr_idx] = wr_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pal_q[i[IDX_W-1:0]] <= default_rgb(i);
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  // Stage 1 only captures on a real request so an idle (possibly X) index never reaches the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_dim_q   <= '0;
      s1_rgb_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_rgb_q <= pal_q[in_idx];
        s1_dim_q <= dim;
      end
    end
  end

  always_comb begin
    out_rgb_d = out_rgb_q;
    if (s1_valid_q) begin
      for (int unsigned c = 0; c < 3; c++) begin
        out_rgb_d[c*CW +: CH_W] = s1_rgb_q[c*CW +: CH_W] >> s1_dim_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rgb   = out_rgb_q;

endmodule

// File: tb/tb_palette_mapper.sv
// Bench for palette_mapper: default 4/8 build checked against a palette/latency model,
// plus a 5/4 build checked for width scaling and out-of-table defaults.
module tb_palette_mapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_idx;
  logic [1:0]  dim;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [23:0] wr_rgb;
  logic        restore;
  logic        out_valid;
  logic [23:0] out_rgb;

  logic        b_in_valid;
  logic [4:0]  b_in_idx;
  logic [1:0]  b_dim;
  logic        b_out_valid;
  logic [11:0] b_out_rgb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  palette_mapper #(.IDX_W(4), .CH_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx), .dim(dim),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_rgb(wr_rgb), .restore(restore),
    .out_valid(out_valid), .out_rgb(out_rgb)
  );

  palette_mapper #(.IDX_W(5), .CH_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_idx(b_in_idx), .dim(b_dim),
    .wr_en(1'b0), .wr_idx(5'd0), .wr_rgb(12'h000), .restore(1'b0),
    .out_valid(b_out_valid), .out_rgb(b_out_rgb)
  );

  // Reference model: palette contents plus the list of issued lookups, each
  // resolved to its final colour at issue time.
  logic [23:0] def_tab [16] = '{24'h000000, 24'hb97a56, 24'he49a9d, 24'hffaec8,
                                24'h808080, 24'h404040, 24'hc0c0c0, 24'hff00ff,
                                24'h00f0f0, 24'h0000f0, 24'hf0a000, 24'hf0f000,
                                24'h00f000, 24'ha000f0, 24'hf00000, 24'hffffff};
  logic [23:0] mdl [16];
  typedef struct { bit v; logic [23:0] rgb; } req_t;
  req_t        pipe [$];
  bit          exp_v;
  logic [23:0] exp_rgb;

  function automatic logic [23:0] dimf(input logic [23:0] c, input int d);
    logic [7:0] r, g, b;
    r = c[23:16] >> d;
    g = c[15:8]  >> d;
    b = c[7:0]   >> d;
    return {r, g, b};
  endfunction

  task automatic model_reset();
    pipe.delete();
    exp_v   = 1'b0;
    exp_rgb = 24'h0;
    for (int i = 0; i < 16; i++) mdl[i] = def_tab[i];
  endtask

  // One clock: drive at negedge, update model at posedge, return #1 after the edge.
  task automatic step(input bit v, input int idx, input int d,
                      input bit we, input int widx, input logic [23:0] wrgb, input bit rs);
    req_t r;
    @(negedge clk);
    in_valid = v;
    in_idx   = v ? idx[3:0] : 4'bx;
    dim      = d[1:0];
    wr_en    = we;
    wr_idx   = widx[3:0];
    wr_rgb   = wrgb;
    restore  = rs;
    @(posedge clk);
    r.v   = v;
    r.rgb = v ? dimf(mdl[idx], d) : 24'h0;
    pipe.push_back(r);
    if (rs) begin
      for (int i = 0; i < 16; i++) mdl[i] = def_tab[i];
    end else if (we) begin
      mdl[widx] = wrgb;
    end
    if (pipe.size() > 1) begin
      r = pipe.pop_front();
      exp_v = r.v;
      if (r.v) exp_rgb = r.rgb;
    end
    #1;
  endtask

  task automatic test_reset();
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    tests++;
    if (out_rgb !== 24'h0) begin
      fails++; $display("FAIL reset_rgb got %h exp 000000", out_rgb);
    end
    tests++;
    if (b_out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_small_valid got %b exp 0", b_out_valid);
    end
    tests++;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 18; k++) begin
      step(k < 16, k, 0, 1'b0, 0, 24'h0, 1'b0);
      if (out_valid !== exp_v || out_rgb !== exp_rgb) begin
        fails++;
        $display("FAIL stream k=%0d got %b/%h exp %b/%h", k, out_valid, out_rgb, exp_v, exp_rgb);
      end
      tests++;
      if (k >= 1 && k <= 16) begin
        if (out_valid !== 1'b1 || out_rgb !== def_tab[k-1]) begin
          fails++;
          $display("FAIL stream_order k=%0d got %b/%h exp 1/%h", k, out_valid, out_rgb, def_tab[k-1]);
        end
        tests++;
      end
    end
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL stream_end_valid got %b exp 0", out_valid);
    end
    tests++;
  endtask

  task automatic test_write_same_cycle();
    logic [23:0] lit [4] = '{24'h0, 24'h808080, 24'h123456, 24'h123456};
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       step(1'b1, 4, 0, 1'b1, 4, 24'h123456, 1'b0);
        1:       step(1'b1, 4, 0, 1'b0, 0, 24'h0, 1'b0);
        default: step(1'b0, 0, 0, 1'b0, 0, 24'h0, 1'b0);
      endcase
      if (out_valid !== exp_v || out_rgb !== exp_rgb) begin
        fails++;
        $display("FAIL wr_same k=%0d got %b/%h exp %b/%h", k, out_valid, out_rgb, exp_v, exp_rgb);
      end
      tests++;
      if (k == 1 || k == 2) begin
        if (out_rgb !== lit[k]) begin
          fails++; $display("FAIL wr_same_value k=%0d got %h exp %h", k, out_rgb, lit[k]);
        end
        tests++;
      end
    end
  endtask

  task automatic test_dim();
    int          idxs [6] = '{15, 15, 15, 10, 0, 0};
    int          dims [6] = '{1, 2, 3, 1, 0, 0};
    logic [23:0] lit  [6] = '{24'h0, 24'h7f7f7f, 24'h3f3f3f, 24'h1f1f1f, 24'h785000, 24'h785000};
    for (int k = 0; k < 6; k++) begin
      step(k < 4, idxs[k], dims[k], 1'b0, 0, 24'h0, 1'b0);
      if (out_valid !== exp_v || out_rgb !== exp_rgb) begin
        fails++;
        $display("FAIL dim k=%0d got %b/%h exp %b/%h", k, out_valid, out_rgb, exp_v, exp_rgb);
      end
      tests++;
      if (k >= 1 && k <= 4) begin
        if (out_rgb !== lit[k]) begin
          fails++; $display("FAIL dim_value k=%0d got %h exp %h", k, out_rgb, lit[k]);
        end
        tests++;
      end
    end
  endtask

  task automatic test_restore();
    logic [23:0] lit [6] = '{24'h0, 24'h0, 24'habcdef, 24'h00f0f0, 24'h0000f0, 24'h0};
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       step(1'b0, 0, 0, 1'b1, 8, 24'habcdef, 1'b0);
        1:       step(1'b1, 8, 0, 1'b1, 9, 24'h111111, 1'b1);
        2:       step(1'b1, 8, 0, 1'b0, 0, 24'h0, 1'b0);
        3:       step(1'b1, 9, 0, 1'b0, 0, 24'h0, 1'b0);
        default: step(1'b0, 0, 0, 1'b0, 0, 24'h0, 1'b0);
      endcase
      if (out_valid !== exp_v || out_rgb !== exp_rgb) begin
        fails++;
        $display("FAIL restore k=%0d got %b/%h exp %b/%h", k, out_valid, out_rgb, exp_v, exp_rgb);
      end
      tests++;
      if (k >= 2 && k <= 4) begin
        if (out_rgb !== lit[k]) begin
          fails++; $display("FAIL restore_value k=%0d got %h exp %h", k, out_rgb, lit[k]);
        end
        tests++;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(3) != 0, $urandom_range(15), $urandom_range(3),
           $urandom_range(3) == 0, $urandom_range(15), 24'($urandom),
           $urandom_range(40) == 0);
      if (out_valid !== exp_v || out_rgb !== exp_rgb) begin
        fails++;
        $display("FAIL random k=%0d got %b/%h exp %b/%h", k, out_valid, out_rgb, exp_v, exp_rgb);
      end
      tests++;
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 0, 0, 1'b1, 1, 24'h5a5a5a, 1'b0);
    step(1'b1, 1, 0, 1'b0, 0, 24'h0, 1'b0);
    step(1'b1, 2, 0, 1'b0, 0, 24'h0, 1'b0);
    if (out_valid !== 1'b1 || out_rgb !== 24'h5a5a5a) begin
      fails++; $display("FAIL midrst_pre got %b/%h exp 1/5a5a5a", out_valid, out_rgb);
    end
    tests++;
    #2 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_async_valid got %b exp 0", out_valid);
    end
    tests++;
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(k == 2, 1, 0, 1'b0, 0, 24'h0, 1'b0);
      if (out_valid !== exp_v || out_rgb !== exp_rgb) begin
        fails++;
        $display("FAIL midrst k=%0d got %b/%h exp %b/%h", k, out_valid, out_rgb, exp_v, exp_rgb);
      end
      tests++;
      if (k == 3 && (out_valid !== 1'b1 || out_rgb !== 24'hb97a56)) begin
        fails++; $display("FAIL midrst_revert got %b/%h exp 1/b97a56", out_valid, out_rgb);
      end
      if (k == 3) tests++;
    end
  endtask

  task automatic test_small_build();
    int          idxs [3] = '{20, 10, 15};
    int          dims [3] = '{0, 0, 2};
    logic [11:0] lit  [3] = '{12'h000, 12'hfa0, 12'h333};
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      b_in_valid = (s < 3);
      b_in_idx   = (s < 3) ? idxs[s][4:0] : 5'bx;
      b_dim      = (s < 3) ? dims[s][1:0] : 2'd0;
      @(posedge clk);
      #1;
      if (s >= 1 && s <= 3) begin
        if (b_out_valid !== 1'b1 || b_out_rgb !== lit[s-1]) begin
          fails++;
          $display("FAIL small s=%0d got %b/%h exp 1/%h", s, b_out_valid, b_out_rgb, lit[s-1]);
        end
        tests++;
      end else if (s == 4) begin
        if (b_out_valid !== 1'b0 || b_out_rgb !== 12'h333) begin
          fails++;
          $display("FAIL small_idle got %b/%h exp 0/333", b_out_valid, b_out_rgb);
        end
        tests++;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_idx     = 4'bx;
    dim        = 2'd0;
    wr_en      = 1'b0;
    wr_idx     = 4'd0;
    wr_rgb     = 24'h0;
    restore    = 1'b0;
    b_in_valid = 1'b0;
    b_in_idx   = 5'bx;
    b_dim      = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_stream();
    test_write_same_cycle();
    test_dim();
    test_restore();
    test_random();
    test_reset_midstream();
    test_small_build();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
